// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN       : width of writeback data
//   REG_ADDR_W : register address width
//   NUM_REGS   : number of architectural registers (x0 reads as zero)
//   wb_req_t   : packed writeback request {addr, data}
package regfile_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   valid_i    : request valids {req1, req0}
//   advance_i  : a transfer happened this cycle; move the pointer
//   grant_o    : one-hot grant {req1, req0}, combinational
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // last_q = 1 means req1 was granted most recently
  logic last_q;
  logic last_d;

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    grant_o = 2'b00;
    if (rst) begin
      grant_o = 2'b00;
    end else begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Pointer next state: only a real transfer moves it
  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = grant_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset makes req1 the last winner so req0 goes first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto a single register-file write port.
//   clk, rst                         : clock, synchronous active-high reset
//   req0_valid/addr/data/ready       : ALU writeback request and handshake
//   req1_valid/addr/data/ready       : load writeback request and handshake
//   wr_address, data, write_enable   : registered register-file write port
//   busy_mask                        : one-hot of the register being written
//   grant_id                         : source of the current write (0/1)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = regfile_wb_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_wb_arbiter_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]       req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]       req1_data,
  output logic                  req1_ready,
  output logic [REG_ADDR_W-1:0] wr_address,
  output logic [XLEN-1:0]       data,
  output logic                  write_enable,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  grant_id
);

  logic [1:0]            grant_s;
  logic                  advance_s;
  logic [REG_ADDR_W-1:0] sel_addr_s;
  logic [XLEN-1:0]       sel_data_s;

  logic [REG_ADDR_W-1:0] wr_address_q, wr_address_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  write_enable_q, write_enable_d;
  logic [NUM_REGS-1:0]   busy_mask_q, busy_mask_d;
  logic                  grant_id_q, grant_id_d;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_i   ({req1_valid, req0_valid}),
    .advance_i (advance_s),
    .grant_o   (grant_s)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer
  assign advance_s  = |grant_s;
  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  // Select the granted request
  always_comb begin
    if (grant_s[1]) begin
      sel_addr_s = req1_addr;
      sel_data_s = req1_data;
    end else begin
      sel_addr_s = req0_addr;
      sel_data_s = req0_data;
    end
  end

  // Next write-port state; idle cycles hold address/data/id and drop the strobe
  always_comb begin
    wr_address_d   = wr_address_q;
    data_d         = data_q;
    grant_id_d     = grant_id_q;
    write_enable_d = 1'b0;
    busy_mask_d    = '0;
    if (advance_s) begin
      wr_address_d   = sel_addr_s;
      data_d         = sel_data_s;
      grant_id_d     = grant_s[1];
      // x0 is accepted but never written
      write_enable_d = (sel_addr_s != '0);
    end else begin
      write_enable_d = 1'b0;
    end
    if (write_enable_d) begin
      busy_mask_d[sel_addr_s] = 1'b1;
    end else begin
      busy_mask_d = '0;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_address_q   <= '0;
      data_q         <= '0;
      grant_id_q     <= 1'b0;
      write_enable_q <= 1'b0;
      busy_mask_q    <= '0;
    end else begin
      wr_address_q   <= wr_address_d;
      data_q         <= data_d;
      grant_id_q     <= grant_id_d;
      write_enable_q <= write_enable_d;
      busy_mask_q    <= busy_mask_d;
    end
  end

  assign wr_address   = wr_address_q;
  assign data         = data_q;
  assign grant_id     = grant_id_q;
  assign write_enable = write_enable_q;
  assign busy_mask    = busy_mask_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, 32, data width of every write request and of the write port.
REQ-002 Parameter REG_ADDR_W, 5, register address width; 32 architectural registers, x0 hardwired zero.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0_valid  input  1  writeback request from ALU path.
REQ-006 req0_addr  input  REG_ADDR_W  destination register of req0.
REQ-007 req0_data  input  XLEN  write value of req0.
REQ-008 req0_ready  output  1  req0 accepted this cycle.
REQ-009 req1_valid / req1_addr / req1_data / req1_ready: same widths and meaning for the load-writeback path.
REQ-010 wr_address  output  REG_ADDR_W  register file write address.
REQ-011 data  output  XLEN  register file write data.
REQ-012 write_enable  output  1  register file write strobe.
REQ-013 busy_mask  output  32  one-hot of the register being written this cycle; bit 0 always 0.
REQ-014 grant_id  output  1  source of the write currently on the write port (0 = req0, 1 = req1).

Function
REQ-015 Handshake: a transfer occurs on a cycle where reqN_valid and reqN_ready are both 1; a requester holds valid, addr and data stable until accepted.
REQ-016 reqN_ready is combinational from the valids and arbiter state; at most one ready is high per cycle.
REQ-017 Only one valid: that requester is granted the same cycle.
REQ-018 Both valid: round-robin; the requester not granted most recently wins; the loser's ready stays 0.
REQ-019 Round-robin pointer updates only on a transfer; idle cycles leave it unchanged.
REQ-020 Latency: a transfer in cycle N drives wr_address, data, grant_id and write_enable in cycle N+1, registered, for exactly one cycle.
REQ-021 No transfer in cycle N: write_enable = 0 in N+1; wr_address, data and grant_id hold their previous values.
REQ-022 Address 0: the request is accepted normally (ready = 1, pointer advances) but write_enable stays 0 in N+1.
REQ-023 busy_mask in cycle N+1 equals (1 << wr_address) when write_enable = 1, else all zero.
REQ-024 Back-to-back transfers sustain one write per cycle with no bubble.
REQ-025 Same destination from both requesters in consecutive grants: both writes issue in grant order; the later grant's value persists.
REQ-026 Requester deasserting valid before acceptance is treated as a withdrawn request; no write occurs.

Reset
REQ-027 While rst = 1: req0_ready = req1_ready = 0; no transfer occurs.
REQ-028 Cycle after rst is sampled high: write_enable = 0, wr_address = 0, data = 0, grant_id = 0, busy_mask = 0.
REQ-029 Reset sets the pointer so req1 counts as last granted; req0 wins the first contended cycle.
REQ-030 Reset asserted during a cycle whose transfer would otherwise complete discards that transfer; no write issues afterwards.

Structure
REQ-031 Shared package holds XLEN, REG_ADDR_W, NUM_REGS = 32 and a packed writeback-request struct {addr, data}.
REQ-032 Arbitration logic lives in one sub-module, rr_arbiter2: inputs two valids and the advance strobe, outputs one-hot grant.
REQ-033 Top level holds only the output register stage and busy_mask decode.

Verification
REQ-034 req0 only, addr 5, data 0xDEADBEEF -> req0_ready same cycle; next cycle write_enable = 1, wr_address = 5, busy_mask = 0x00000020, grant_id = 0.
REQ-035 Both valid continuously for 4 cycles after reset -> grants alternate req0, req1, req0, req1; writes appear one cycle later, no gaps.
REQ-036 req1 addr 0, data 0x1234 -> req1_ready = 1; next cycle write_enable = 0, busy_mask = 0.
REQ-037 req0 addr 7 data 0x11 and req1 addr 7 data 0x22 contended -> two writes to 7, 0x11 then 0x22; register 7 reads 0x22 afterwards.
REQ-038 rst asserted with both valids high -> both ready 0; next cycle write_enable = 0; after release req0 wins first.
